// File: rtl/mac_engine.sv
// Three-stream multiply / multiply-accumulate engine with a two-stage pipeline and a backpressured result stream.
// Build option: define MAC_ENGINE_SATURATE_EN to saturate instead of wrapping the shift result and stage-2 sums.
package mac_engine_pkg;
   localparam int MAC_CNT_LEN = 255;
   localparam int CNT_W       = $clog2(MAC_CNT_LEN) + 1;
   localparam int SHIFT_W     = 6;

   typedef struct packed {
      logic               clear;
      logic               enable;
      logic               simple_mul;
      logic               start;
      logic [SHIFT_W-1:0] shift;
      logic [CNT_W-1:0]   len;
   } ctrl_engine_t;

   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic             acc_valid;
   } flags_engine_t;
endpackage

module mac_engine
   import mac_engine_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  ctrl_engine_t  ctrl_i,
   output flags_engine_t flags_o,
   input  logic [DW-1:0] a_data_i,
   input  logic          a_valid_i,
   output logic          a_ready_o,
   input  logic [DW-1:0] b_data_i,
   input  logic          b_valid_i,
   output logic          b_ready_o,
   input  logic [DW-1:0] c_data_i,
   input  logic          c_valid_i,
   output logic          c_ready_o,
   output logic [DW-1:0] d_data_o,
   output logic          d_valid_o,
   input  logic          d_ready_i
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t               state_q, state_d;
   logic                 simpleMul_q;
   logic [SHIFT_W-1:0]   shift_q;
   logic [CNT_W-1:0]     len_q, cnt_q;
   logic [DW-1:0]        acc_q, s1Data_q, s1C_q, dData_q;
   logic                 s1Valid_q, s1Last_q, dValid_q, dLast_q, accValid_q;

   logic                 fire, s1Advance, dHandshake, lastPair;
   logic signed [2*DW-1:0] prod, shifted;
   logic [DW-1:0]        sum;

`ifdef MAC_ENGINE_SATURATE_EN
   function automatic logic [DW-1:0] fitToWord(input logic [2*DW-1:0] v);
      if (v[2*DW-1:DW-1] == '0 || v[2*DW-1:DW-1] == '1) return v[DW-1:0];
      else if (v[2*DW-1]) return {1'b1, {(DW-1){1'b0}}};
      else return {1'b0, {(DW-1){1'b1}}};
   endfunction

   function automatic logic [DW-1:0] addOp(input logic [DW-1:0] x, input logic [DW-1:0] y);
      logic [DW:0] t;
      t = {x[DW-1], x} + {y[DW-1], y};
      if (t[DW] == t[DW-1]) return t[DW-1:0];
      else if (t[DW]) return {1'b1, {(DW-1){1'b0}}};
      else return {1'b0, {(DW-1){1'b1}}};
   endfunction
`else
   function automatic logic [DW-1:0] fitToWord(input logic [2*DW-1:0] v);
      return v[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] addOp(input logic [DW-1:0] x, input logic [DW-1:0] y);
      return x + y;
   endfunction
`endif

   // Handshake qualifiers: stage 1 may refill in the same cycle it drains into stage 2.
   always_comb begin
      dHandshake = dValid_q & d_ready_i;
      s1Advance  = ctrl_i.enable & s1Valid_q & (~dValid_q | d_ready_i);
      fire       = (state_q == RUN) & ctrl_i.enable & a_valid_i & b_valid_i &
                   (c_valid_i | ~simpleMul_q) & (~s1Valid_q | s1Advance) & (cnt_q < len_q);
      lastPair   = ((cnt_q + CNT_ONE) == len_q);
      prod       = {{DW{a_data_i[DW-1]}}, a_data_i} * {{DW{b_data_i[DW-1]}}, b_data_i};
      shifted    = prod >>> shift_q;
      sum        = addOp(simpleMul_q ? s1C_q : acc_q, s1Data_q);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (ctrl_i.start && ctrl_i.len != '0) state_d = RUN;
         RUN:     if (fire && lastPair) state_d = DRAIN;
         DRAIN:   if (dHandshake && dLast_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || ctrl_i.clear) begin
         state_q     <= IDLE;
         simpleMul_q <= 1'b0;
         shift_q     <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         s1Data_q    <= '0;
         s1C_q       <= '0;
         s1Valid_q   <= 1'b0;
         s1Last_q    <= 1'b0;
         dData_q     <= '0;
         dValid_q    <= 1'b0;
         dLast_q     <= 1'b0;
         accValid_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && ctrl_i.start) begin
            cnt_q <= '0;
            acc_q <= '0;
            if (ctrl_i.len != '0) begin
               simpleMul_q <= ctrl_i.simple_mul;
               shift_q     <= ctrl_i.shift;
               len_q       <= ctrl_i.len;
            end
         end
         if (fire) begin
            cnt_q     <= cnt_q + CNT_ONE;
            s1Data_q  <= fitToWord(shifted);
            s1C_q     <= c_data_i;
            s1Last_q  <= lastPair;
            s1Valid_q <= 1'b1;
         end else if (s1Advance) begin
            s1Valid_q <= 1'b0;
         end
         if (dHandshake) begin
            dValid_q   <= 1'b0;
            accValid_q <= 1'b0;
         end
         // Accumulate mode only presents a beat once the final pair has been summed.
         if (s1Advance) begin
            if (simpleMul_q) begin
               dData_q    <= sum;
               dValid_q   <= 1'b1;
               dLast_q    <= s1Last_q;
               accValid_q <= 1'b0;
            end else begin
               acc_q <= sum;
               if (s1Last_q) begin
                  dData_q    <= sum;
                  dValid_q   <= 1'b1;
                  dLast_q    <= 1'b1;
                  accValid_q <= 1'b1;
               end
            end
         end
      end
   end

   assign a_ready_o         = fire;
   assign b_ready_o         = fire;
   assign c_ready_o         = fire & simpleMul_q;
   assign d_data_o          = dData_q;
   assign d_valid_o         = dValid_q;
   assign flags_o.cnt       = cnt_q;
   assign flags_o.acc_valid = accValid_q;
endmodule

// File: tb/tb_mac_engine.sv
// Scoreboard bench for mac_engine: stimulus pushes expected D beats, an independent monitor pops and compares them.
module tb_mac_engine;
   import mac_engine_pkg::*;

   localparam int DW = 32;

   typedef struct {
      logic [DW-1:0] data;
      logic          accv;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_i;
   ctrl_engine_t  ctrl_i;
   flags_engine_t flags_o;
   logic [DW-1:0] a_data_i, b_data_i, c_data_i, d_data_o;
   logic          a_valid_i, b_valid_i, c_valid_i, d_ready_i;
   logic          a_ready_o, b_ready_o, c_ready_o, d_valid_o;

   exp_t sbQ[$];
   int   assertCount = 0;
   int   failCount   = 0;
   bit   cReadySeen  = 1'b0;
   bit   watchCReady = 1'b0;

   mac_engine #(.DW(DW)) dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .ctrl_i   (ctrl_i),
      .flags_o  (flags_o),
      .a_data_i (a_data_i),
      .a_valid_i(a_valid_i),
      .a_ready_o(a_ready_o),
      .b_data_i (b_data_i),
      .b_valid_i(b_valid_i),
      .b_ready_o(b_ready_o),
      .c_data_i (c_data_i),
      .c_valid_i(c_valid_i),
      .c_ready_o(c_ready_o),
      .d_data_o (d_data_o),
      .d_valid_o(d_valid_o),
      .d_ready_i(d_ready_i)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: every completed D handshake must match the oldest expected beat.
   always @(negedge clk) begin
      if (watchCReady && c_ready_o) cReadySeen = 1'b1;
      if (!rst_i && d_valid_o && d_ready_i) begin
         if (sbQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpected_d_beat: got 0x%08h, expected no beat", d_data_o);
         end else begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput("d_data", d_data_o, e.data);
            checkOutput("acc_valid", 32'(flags_o.acc_valid), 32'(e.accv));
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                input bit pushIt, input logic [31:0] expData, input bit expAccv);
      bit fired = 1'b0;
      a_data_i = a; b_data_i = b; c_data_i = c;
      a_valid_i = 1'b1; b_valid_i = 1'b1; c_valid_i = 1'b1;
      for (int k = 0; k < 40 && !fired; k++) begin
         @(negedge clk);
         fired = a_ready_o;
         @(posedge clk);
         #1;
      end
      if (!fired) checkOutput("fire_timeout", 32'd0, 32'd1);
      else if (pushIt) sbQ.push_back('{expData, expAccv});
   endtask

   task automatic idleInputs();
      a_valid_i = 1'b0; b_valid_i = 1'b0; c_valid_i = 1'b0;
   endtask

   task automatic startJob(input bit simple, input logic [SHIFT_W-1:0] sh, input logic [CNT_W-1:0] len);
      ctrl_i.start = 1'b1; ctrl_i.simple_mul = simple; ctrl_i.shift = sh; ctrl_i.len = len;
      @(posedge clk);
      #1;
      ctrl_i.start = 1'b0;
   endtask

   task automatic waitDrain();
      int k = 0;
      while ((sbQ.size() != 0 || d_valid_o) && k < 100) begin
         @(negedge clk);
         k++;
      end
      checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_i = 1'b1;
      ctrl_i = '0;
      ctrl_i.enable = 1'b1;
      a_data_i = '0; b_data_i = '0; c_data_i = '0;
      a_valid_i = 1'b1; b_valid_i = 1'b1; c_valid_i = 1'b1;
      d_ready_i = 1'b1;

      // Reset state with every input stream offering data.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_d_valid", 32'(d_valid_o), 32'd0);
      checkOutput("rst_d_data", d_data_o, 32'd0);
      checkOutput("rst_a_ready", 32'(a_ready_o), 32'd0);
      checkOutput("rst_c_ready", 32'(c_ready_o), 32'd0);
      checkOutput("rst_cnt", 32'(flags_o.cnt), 32'd0);
      checkOutput("rst_acc_valid", 32'(flags_o.acc_valid), 32'd0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      idleInputs();

      // Simple multiply-add: 2*5+1, -3*4+1, 7*-1+1.
      startJob(1'b1, 6'd0, CNT_W'(3));
      applyStimulus(2, 5, 1, 1'b1, 11, 1'b0);
      applyStimulus(-3, 4, 1, 1'b1, -11, 1'b0);
      applyStimulus(7, -1, 1, 1'b1, -6, 1'b0);
      idleInputs();
      waitDrain();
      checkOutput("simple_cnt", 32'(flags_o.cnt), 32'd3);
      checkOutput("simple_state_idle", 32'(dut.state_q), 32'd0);

      // Accumulate with shift 1: (2+4+6+8)>>1 per term = 1+2+3+4.
      cReadySeen = 1'b0;
      watchCReady = 1'b1;
      startJob(1'b0, 6'd1, CNT_W'(4));
      applyStimulus(1, 2, 99, 1'b0, 0, 1'b0);
      applyStimulus(2, 2, 99, 1'b0, 0, 1'b0);
      applyStimulus(3, 2, 99, 1'b0, 0, 1'b0);
      applyStimulus(4, 2, 99, 1'b1, 10, 1'b1);
      idleInputs();
      waitDrain();
      watchCReady = 1'b0;
      checkOutput("accum_c_ready_never", 32'(cReadySeen), 32'd0);
      checkOutput("accum_cnt", 32'(flags_o.cnt), 32'd4);

      // Backpressure: results 3, 16, 29, 42 must survive a 5-cycle stall in order.
      d_ready_i = 1'b0;
      startJob(1'b1, 6'd0, CNT_W'(4));
      fork
         begin
            applyStimulus(1, 3, 0, 1'b1, 3, 1'b0);
            applyStimulus(2, 3, 10, 1'b1, 16, 1'b0);
            applyStimulus(3, 3, 20, 1'b1, 29, 1'b0);
            applyStimulus(4, 3, 30, 1'b1, 42, 1'b0);
            idleInputs();
         end
         begin
            repeat (5) begin
               @(negedge clk);
               if (d_valid_o) checkOutput("stall_d_stable", d_data_o, 32'd3);
            end
            checkOutput("stall_a_ready_low", 32'(a_ready_o), 32'd0);
            checkOutput("stall_d_valid_held", 32'(d_valid_o), 32'd1);
            @(posedge clk);
            #1;
            d_ready_i = 1'b1;
         end
      join
      waitDrain();

      // Overflow boundary: 0x10000 * 0x8000 = 2^31 does not fit a signed 32-bit word.
      startJob(1'b0, 6'd0, CNT_W'(1));
`ifdef MAC_ENGINE_SATURATE_EN
      applyStimulus(32'h0001_0000, 32'h0000_8000, 0, 1'b1, 32'h7FFF_FFFF, 1'b1);
`else
      applyStimulus(32'h0001_0000, 32'h0000_8000, 0, 1'b1, 32'h8000_0000, 1'b1);
`endif
      idleInputs();
      waitDrain();

      // Clear after two of four pairs: no beat, then a fresh job 3*5+4*6.
      startJob(1'b0, 6'd0, CNT_W'(4));
      applyStimulus(1, 1, 0, 1'b0, 0, 1'b0);
      applyStimulus(2, 1, 0, 1'b0, 0, 1'b0);
      idleInputs();
      ctrl_i.clear = 1'b1;
      @(posedge clk);
      #1;
      ctrl_i.clear = 1'b0;
      checkOutput("clear_cnt", 32'(flags_o.cnt), 32'd0);
      checkOutput("clear_state_idle", 32'(dut.state_q), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("clear_no_d", 32'(d_valid_o), 32'd0);
      startJob(1'b0, 6'd0, CNT_W'(2));
      applyStimulus(3, 5, 0, 1'b0, 0, 1'b0);
      applyStimulus(4, 6, 0, 1'b1, 39, 1'b1);
      idleInputs();
      waitDrain();

      // Start while running must not change the latched length or mode.
      startJob(1'b1, 6'd0, CNT_W'(2));
      applyStimulus(3, 4, 5, 1'b1, 17, 1'b0);
      idleInputs();
      startJob(1'b0, 6'd3, CNT_W'(5));
      applyStimulus(-2, 5, 5, 1'b1, -5, 1'b0);
      repeat (3) begin
         @(negedge clk);
         checkOutput("run_start_len_kept", 32'(a_ready_o), 32'd0);
      end
      @(posedge clk);
      #1;
      idleInputs();
      waitDrain();
      checkOutput("run_start_cnt", 32'(flags_o.cnt), 32'd2);
      checkOutput("run_start_state_idle", 32'(dut.state_q), 32'd0);

      // Zero-length start stays idle with the count cleared.
      startJob(1'b1, 6'd0, CNT_W'(0));
      a_valid_i = 1'b1; b_valid_i = 1'b1; c_valid_i = 1'b1;
      @(negedge clk);
      checkOutput("len0_state_idle", 32'(dut.state_q), 32'd0);
      checkOutput("len0_cnt", 32'(flags_o.cnt), 32'd0);
      checkOutput("len0_a_ready", 32'(a_ready_o), 32'd0);
      @(posedge clk);
      #1;
      idleInputs();

      // Reset mid-job aborts silently; a start right after reset works.
      startJob(1'b1, 6'd0, CNT_W'(2));
      applyStimulus(2, 3, 0, 1'b0, 0, 1'b0);
      idleInputs();
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      checkOutput("abort_d_valid", 32'(d_valid_o), 32'd0);
      startJob(1'b1, 6'd0, CNT_W'(1));
      applyStimulus(2, 2, 1, 1'b1, 5, 1'b0);
      idleInputs();
      waitDrain();
      checkOutput("abort_state_idle", 32'(dut.state_q), 32'd0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
